// File: rtl/spi_sram_seq.sv
// spi_sram_seq: SPI mode-0 SRAM slave with byte/page/sequential modes, status register and burst wrap.
// Optional macro SPI_SRAM_HOLD_EN enables the holdb pause; when undefined holdb is ignored.
module spi_sram_seq #(
    parameter int         ADDR_BITS  = 13,
    parameter int         ADDR_BYTES = 2,
    parameter int         PAGE_BYTES = 32,
    parameter logic [1:0] MODE_RST   = 2'b01
) (
    input  logic sck,
    input  logic rstb,
    input  logic csb,
    input  logic si,
    input  logic holdb,
    output wire  so
);
    localparam int DEPTH       = 2 ** ADDR_BITS;
    localparam int ADDR_SHIFTS = ADDR_BYTES * 8;
    localparam int CW          = $clog2(ADDR_SHIFTS);

    localparam logic [ADDR_BITS-1:0] PAGE_MASK = ADDR_BITS'(PAGE_BYTES - 1);
    localparam logic [ADDR_BITS-1:0] ADDR_ONE  = ADDR_BITS'(1);
    localparam logic [CW-1:0]        CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]        ADDR_LAST = CW'(ADDR_SHIFTS - 1);

    typedef enum logic [2:0] {
        ST_CMD,
        ST_ADDR,
        ST_READ,
        ST_WRITE,
        ST_RDSR,
        ST_WRSR,
        ST_IGNORE,
        ST_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [6:0]           shift_q, shift_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [1:0]           mode_q, mode_d;
    logic                 is_write_q, is_write_d;
    logic                 so_q, so_en_q;

    logic [7:0]           mem [DEPTH];
    logic                 mem_we;
    logic                 freeze;
    logic                 byte_last;
    logic                 byte_mode;
    logic [7:0]           rx_byte;
    logic [7:0]           status;
    logic [2:0]           bit_idx;
    logic [ADDR_BITS-1:0] addr_next;

`ifdef SPI_SRAM_HOLD_EN
    assign freeze = ~holdb;
    assign so     = (csb || !holdb || !so_en_q) ? 1'bz : so_q;
`else
    logic unused_holdb;
    assign unused_holdb = holdb;
    assign freeze       = 1'b0;
    assign so           = (csb || !so_en_q) ? 1'bz : so_q;
`endif

    assign rx_byte   = {shift_q, si};
    assign status    = {mode_q, 6'b0};
    assign byte_last = (cnt_q[2:0] == 3'd7);
    assign bit_idx   = 3'd7 - cnt_q[2:0];
    // Modes 00 and 11 both stop after a single byte.
    assign byte_mode = (mode_q[1] == mode_q[0]);
    assign addr_next = mode_q[1] ? ((addr_q & ~PAGE_MASK) | ((addr_q + ADDR_ONE) & PAGE_MASK))
                                 : (addr_q + ADDR_ONE);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        addr_d     = addr_q;
        mode_d     = mode_q;
        is_write_d = is_write_q;
        mem_we     = 1'b0;
        if (csb) begin
            state_d = ST_CMD;
            cnt_d   = '0;
        end else if (!freeze) begin
            case (state_q)
                ST_CMD: begin
                    shift_d = {shift_q[5:0], si};
                    cnt_d   = cnt_q + CNT_ONE;
                    if (byte_last) begin
                        cnt_d = '0;
                        case (rx_byte)
                            8'h03: begin
                                state_d    = ST_ADDR;
                                is_write_d = 1'b0;
                            end
                            8'h02: begin
                                state_d    = ST_ADDR;
                                is_write_d = 1'b1;
                            end
                            8'h05:   state_d = ST_RDSR;
                            8'h01:   state_d = ST_WRSR;
                            default: state_d = ST_IGNORE;
                        endcase
                    end
                end
                ST_ADDR: begin
                    // Older bits fall off the top, leaving the low ADDR_BITS of the field.
                    addr_d = {addr_q[ADDR_BITS-2:0], si};
                    cnt_d  = cnt_q + CNT_ONE;
                    if (cnt_q == ADDR_LAST) begin
                        cnt_d   = '0;
                        state_d = is_write_q ? ST_WRITE : ST_READ;
                    end
                end
                ST_READ, ST_WRITE: begin
                    shift_d = {shift_q[5:0], si};
                    cnt_d   = cnt_q + CNT_ONE;
                    if (byte_last) begin
                        cnt_d  = '0;
                        mem_we = (state_q == ST_WRITE);
                        if (byte_mode) state_d = ST_DONE;
                        else           addr_d  = addr_next;
                    end
                end
                ST_RDSR: begin
                    cnt_d = byte_last ? '0 : cnt_q + CNT_ONE;
                end
                ST_WRSR: begin
                    shift_d = {shift_q[5:0], si};
                    cnt_d   = cnt_q + CNT_ONE;
                    if (byte_last) begin
                        cnt_d   = '0;
                        mode_d  = rx_byte[7:6];
                        state_d = ST_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sck or negedge rstb) begin
        if (!rstb) begin
            state_q    <= ST_CMD;
            cnt_q      <= '0;
            shift_q    <= '0;
            addr_q     <= '0;
            mode_q     <= MODE_RST;
            is_write_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            addr_q     <= addr_d;
            mode_q     <= mode_d;
            is_write_q <= is_write_d;
        end
    end

    always_ff @(posedge sck) begin
        if (mem_we) mem[addr_q] <= rx_byte;
    end

    // Output bits launch on the falling edge so the host samples them on the next rising edge.
    always_ff @(negedge sck or negedge rstb) begin
        if (!rstb) begin
            so_q    <= 1'b0;
            so_en_q <= 1'b0;
        end else begin
            so_en_q <= (state_q == ST_READ) || (state_q == ST_RDSR);
            so_q    <= (state_q == ST_RDSR) ? status[bit_idx] : mem[addr_q][bit_idx];
        end
    end

endmodule

// File: doc/spi_sram_seq.md
Name: spi_sram_seq

Overview:
- Parametrised serial SPI SRAM slave model, mode 0 (CPOL=0, CPHA=0), MSB first; successor to the fixed 8 KB part.
- Adds configurable depth and address bytes, mode register (byte/page/sequential), multi-byte bursts with wrap, status read/write, HOLD pause and async reset.
- Sits on the test/system SPI bus as a memory target; one instance per chip-select.

Parameters:
- ADDR_BITS, 13, internal address width; DEPTH = 2**ADDR_BITS bytes.
- ADDR_BYTES, 2, address bytes sent after the instruction (ADDR_BYTES*8 >= ADDR_BITS).
- PAGE_BYTES, 32, page size for page mode; power of two, <= DEPTH.
- MODE_RST, 2'b01, reset value of mode bits [7:6] (01 = sequential).

Ports:
- sck, input, 1, SPI clock; the only clock. Input sampled on rising edge, so updated on falling edge.
- rstb, input, 1, asynchronous active-low reset.
- csb, input, 1, chip select, active low, sampled on rising sck.
- si, input, 1, serial data in.
- holdb, input, 1, hold, active low, sampled on rising sck.
- so, output, 1, serial data out; tri-state when not driving.

Behaviour:
- Reset (rstb=0, asynchronous): state=CMD, bit counter=0, status=\{MODE_RST,6'b0\}, so=Z. Memory contents are not cleared.
- Frame end:
  - Any rising sck with csb=1 returns state to CMD and clears counters.
  - Host supplies >= 1 rising sck with csb=1 between frames.
  - so=Z combinationally whenever csb=1.
- States: CMD -> ADDR -> READ | WRITE; CMD -> RDSR | WRSR; CMD -> IGNORE for unknown opcodes. IGNORE and DONE both hold so=Z until frame end.
- CMD: 8 bits shifted in.
  - 0x03 -> ADDR (read); 0x02 -> ADDR (write).
  - 0x05 -> RDSR; 0x01 -> WRSR; any other value -> IGNORE.
- ADDR: ADDR_BYTES*8 bits shifted in. Low ADDR_BITS form the start address; upper bits are ignored (aliasing).
- READ:
  - MSB of mem[addr] is driven on the falling edge right after the last address bit is sampled. Zero dummy cycles.
  - Each subsequent falling edge drives the next bit. After 8 bits the address advances per mode.
- WRITE:
  - 8 data bits shifted in; mem[addr] is written on the rising edge that samples bit 0, then the address advances per mode.
  - A partial byte at frame end is discarded; memory is unchanged.
- Address advance by mode bits [7:6]:
  - 00 byte: after one byte -> DONE (so=Z, further si ignored).
  - 10 page: low log2(PAGE_BYTES) bits increment and wrap; upper bits are fixed.
  - 01 sequential: increment, wrap DEPTH-1 -> 0.
  - 11 reserved: behaves as byte.
- RDSR: status byte shifted out MSB first, repeated every 8 clocks until frame end.
- WRSR:
  - On the 8th data bit, status[7:6] <= received[7:6]; status[5:0] stay 0.
  - Further bits are ignored. A partial byte leaves status unchanged.
- Hold:
  - holdb=0 at a rising sck freezes all shift registers, counters and state.
  - so=Z combinationally while holdb=0; the last-driven bit resumes when holdb=1.
  - csb=1 during hold still ends the frame.
- Reset mid-frame: abort immediately to the reset values. An in-progress write byte is lost; completed bytes are kept.

Optional Feature:
- Macro SPI_SRAM_HOLD_EN.
- Defined: holdb behaviour as above.
- Undefined: holdb is ignored (port kept, unconnected internally) and the slave never pauses.

Test Plan:
- Reset -> RDSR (0x05) -> so returns 0x40 twice in 16 clocks; so=Z after csb rises.
- Sequential mode (default): WRITE 0x02, addr 0x1FFE, data A1 B2 C3 -> READ from 0x1FFE returns A1 B2 C3 (wrap to 0x0000); READ from 0x0000 returns C3.
- WRSR 0x80 (page) -> WRITE addr 0x003E, data 11 22 33 -> mem[0x3E]=11, mem[0x3F]=22, mem[0x20]=33; mem[0x40] unchanged; RDSR returns 0x80.
- WRSR 0x00 (byte) -> WRITE addr 0x0010, data 55 66 -> only mem[0x10]=55; READ 0x0010 for 16 clocks -> 55 then so=Z.
- Hold during READ (SPI_SRAM_HOLD_EN defined): assert holdb=0 for 5 clocks mid-byte -> so=Z during hold, byte completes intact after release; with the macro undefined, same stimulus -> bits keep shifting and the byte is corrupted as expected.
- Abort cases: rstb pulse after 5 write-data bits -> target byte unchanged and status = reset value; unknown opcode 0xAB followed by 24 clocks -> so stays Z and memory unchanged.
